pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 de_valid  in  1  DE stage holds a valid instruction.
REQ-005 de_rs1, de_rs2  in  5 each  DE source register addresses (ir[19:15], ir[24:20]).
REQ-006 de_use_rs1, de_use_rs2  in  1 each  DE instruction reads rs1 / rs2.
REQ-007 de_wa  in  5  DE destination register (ir[11:7]).
REQ-008 de_regWrite, de_memRead2  in  1 each  decoder write-back enable and load flag.
REQ-009 ex_br_taken  in  1  EX resolved a taken branch or jump (redirect).
REQ-010 mem_busy  in  1  data memory not ready; the pipeline must freeze.
REQ-011 pc_stall  out  1  hold the PC.
REQ-012 ifde_stall  out  1  hold the IF/DE register.
REQ-013 ifde_flush  out  1  load a NOP into the IF/DE register.
REQ-014 deex_bubble  out  1  load a bubble into the DE/EX register.
REQ-015 fwd_a, fwd_b  out  2 each  operand source: 00 = RF, 01 = EX, 10 = MEM, 11 = WB.
REQ-016 stall_cnt  out  16  saturating count of stall/freeze cycles.

Function
REQ-017 Three tracker slots (EX, MEM, WB), each holding {v, wa[4:0], ld}, SHALL mirror the pipeline contents.
REQ-018 Define freeze = mem_busy.
  - On freeze, all slots, state and forwarding sources SHALL hold.
  - pc_stall = ifde_stall = 1 and deex_bubble = 0.
  - ifde_flush = 0.
REQ-019 When not frozen, each edge SHALL advance the slots: WB <= MEM, MEM <= EX.
  - EX <= {1, de_wa, de_memRead2} when issue = 1.
  - Otherwise EX <= {0, 0, 0}.
  - v SHALL be stored as de_regWrite & (de_wa != 0).
REQ-020 Load-use hazard lu SHALL be asserted when both hold:
  - EX.v & EX.ld;
  - (de_use_rs1 & de_rs1 == EX.wa) | (de_use_rs2 & de_rs2 == EX.wa).
REQ-021 issue SHALL equal de_valid & ~lu & ~flushing & ~freeze, where flushing = ex_br_taken | (state == FLUSH).
REQ-022 When lu is set and not frozen:
  - pc_stall = ifde_stall = 1 and deex_bubble = 1, for exactly 1 cycle per load.
  - The next cycle, the load is in MEM and forwarding selects 10.
REQ-023 FSM states are RUN and FLUSH.
  - RUN -> FLUSH when ex_br_taken & ~freeze.
  - FLUSH -> RUN after 1 cycle.
  - Frozen: the state holds.
REQ-024 In RUN with ex_br_taken & ~freeze:
  - ifde_flush = 1 and deex_bubble = 1;
  - pc_stall = 0, so the redirect PC loads.
REQ-025 In FLUSH (not frozen), ifde_flush SHALL be 1 to kill the in-flight fetch.
  - deex_bubble SHALL be 1.
  - The penalty is 2 cycles total.
REQ-026 Branch takes priority over lu; if both are set, no stall SHALL occur, flush only.
REQ-027 mem_busy takes priority over the branch.
  - ex_br_taken is held by the frozen EX stage.
  - The branch SHALL be acted on in the first cycle mem_busy = 0.
REQ-028 fwd_a (and fwd_b for rs2) SHALL be combinational, with youngest match first:
  - 00 if ~de_use_rs1 or de_rs1 == 0;
  - else 01 if EX.v & ~EX.ld & EX.wa == rs;
  - else 10 if MEM.v & MEM.wa == rs;
  - else 11 if WB.v & WB.wa == rs;
  - else 00.
REQ-029 stall_cnt SHALL increment by 1 on each cycle with (lu | freeze) and not flushing, or with freeze.
  - It SHALL saturate at 16'hFFFF.
REQ-030 de_valid = 0 SHALL produce a bubble (issue = 0) with no stall.

Reset
REQ-031 While reset = 1, asynchronously:
  - all slots SHALL be {0, 0, 0} and state = RUN;
  - stall_cnt = 0 and fwd_a = fwd_b = 00;
  - pc_stall, ifde_stall, ifde_flush and deex_bubble = 0.
REQ-032 Reset asserted mid-flush or mid-freeze SHALL abort it; the first cycle after release SHALL behave as RUN with an empty pipeline.

Verification
REQ-033 lw x5 issued, then add x6,x5,x1 in DE -> 1 cycle with pc_stall = ifde_stall = deex_bubble = 1 and stall_cnt = 1; next cycle fwd_a = 10, no stall.
REQ-034 add x5 followed by sub x7,x5,x5 -> fwd_a = fwd_b = 01 with no stall; the instruction after that reading x5 -> 10, then 11.
REQ-035 ex_br_taken = 1 for 1 cycle -> ifde_flush = 1 for 2 consecutive cycles, deex_bubble = 1 for 2 cycles, pc_stall = 0, state RUN -> FLUSH -> RUN.
REQ-036 mem_busy = 1 for 3 cycles while ex_br_taken = 1 -> no flush during busy; stall_cnt += 3; flush starts on the cycle mem_busy falls.
REQ-037 Source x0 with EX.wa = 0 (write suppressed) -> fwd = 00 and no lu stall, even when the EX instruction is a load.
REQ-038 reset pulsed during the FLUSH state -> all outputs 0 immediately; stall_cnt = 0 held at 16'hFFFF saturation check: force 65535 freeze cycles -> stall_cnt stays at FFFF.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Decode-stage hazard inputs and pipeline steering outputs shared by the
// controller and whatever drives it.
interface pipe_ctrl_if;
  logic        de_valid;
  logic [4:0]  de_rs1;
  logic [4:0]  de_rs2;
  logic        de_use_rs1;
  logic        de_use_rs2;
  logic [4:0]  de_wa;
  logic        de_regWrite;
  logic        de_memRead2;
  logic        ex_br_taken;
  logic        mem_busy;
  logic        pc_stall;
  logic        ifde_stall;
  logic        ifde_flush;
  logic        deex_bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_cnt;

  modport master (
    output de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_wa,
           de_regWrite, de_memRead2, ex_br_taken, mem_busy,
    input  pc_stall, ifde_stall, ifde_flush, deex_bubble, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_wa,
           de_regWrite, de_memRead2, ex_br_taken, mem_busy,
    output pc_stall, ifde_stall, ifde_flush, deex_bubble, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, branch flush, memory
// freeze and operand forwarding, driven by a tracker of the EX/MEM/WB slots.
module pipe_ctrl (
  input  logic clk,
  input  logic reset,
  pipe_ctrl_if.slave bus
);

  typedef struct packed {
    logic       v;
    logic [4:0] wa;
    logic       ld;
  } slot_t;

  typedef enum logic {RUN, FLUSH} state_t;

  slot_t  ex_q, mem_q, wb_q;
  slot_t  ex_d;
  state_t state_q, state_d;
  logic [15:0] cnt_q;

  logic freeze, flushing, lu, issue, bump;
  logic rs1_hit, rs2_hit;

  function automatic logic hit(input slot_t s, input logic [4:0] rs);
    return s.v && (s.wa == rs);
  endfunction

  // Youngest producer wins; a load still in EX cannot forward (load-use stalls).
  function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [4:0] rs,
                                         input slot_t ex, input slot_t mem, input slot_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && rs != 5'd0) begin
      if (hit(ex, rs) && !ex.ld)
        sel = 2'b01;
      else if (hit(mem, rs))
        sel = 2'b10;
      else if (hit(wb, rs))
        sel = 2'b11;
    end
    return sel;
  endfunction

  assign freeze   = bus.mem_busy;
  assign flushing = bus.ex_br_taken || (state_q == FLUSH);
  assign rs1_hit  = bus.de_use_rs1 && (bus.de_rs1 == ex_q.wa);
  assign rs2_hit  = bus.de_use_rs2 && (bus.de_rs2 == ex_q.wa);
  assign lu       = ex_q.v && ex_q.ld && (rs1_hit || rs2_hit);
  assign issue    = bus.de_valid && !lu && !flushing && !freeze;
  assign bump     = (lu && !flushing) || freeze;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.v  = bus.de_regWrite && (bus.de_wa != 5'd0);
      ex_d.wa = bus.de_wa;
      ex_d.ld = bus.de_memRead2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
    end else if (!freeze) begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else if (bump && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  // Outputs are forced quiet while reset is held so an aborted flush/freeze
  // never leaks a stall or flush to the datapath.
  always_comb begin
    state_d         = RUN;
    bus.pc_stall    = 1'b0;
    bus.ifde_stall  = 1'b0;
    bus.ifde_flush  = 1'b0;
    bus.deex_bubble = 1'b0;
    bus.fwd_a       = 2'b00;
    bus.fwd_b       = 2'b00;

    case (state_q)
      RUN:     state_d = bus.ex_br_taken ? FLUSH : RUN;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase

    if (!reset) begin
      bus.fwd_a = fwd_sel(bus.de_use_rs1, bus.de_rs1, ex_q, mem_q, wb_q);
      bus.fwd_b = fwd_sel(bus.de_use_rs2, bus.de_rs2, ex_q, mem_q, wb_q);
      if (freeze) begin
        bus.pc_stall   = 1'b1;
        bus.ifde_stall = 1'b1;
      end else if (flushing) begin
        bus.ifde_flush  = 1'b1;
        bus.deex_bubble = 1'b1;
      end else if (lu) begin
        bus.pc_stall    = 1'b1;
        bus.ifde_stall  = 1'b1;
        bus.deex_bubble = 1'b1;
      end
    end
  end

  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed table-driven bench for pipe_ctrl plus reset-abort and counter
// saturation sequences.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();
  pipe_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] wa;
    logic       rw;
    logic       ld;
    logic       br;
    logic       busy;
    logic       pcs;
    logic       ifs;
    logic       fl;
    logic       bub;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.de_valid    = t.v;
    bus.de_rs1      = t.rs1;
    bus.de_rs2      = t.rs2;
    bus.de_use_rs1  = t.u1;
    bus.de_use_rs2  = t.u2;
    bus.de_wa       = t.wa;
    bus.de_regWrite = t.rw;
    bus.de_memRead2 = t.ld;
    bus.ex_br_taken = t.br;
    bus.mem_busy    = t.busy;
  endtask

  task automatic chk_all(input string tag, input vec_t t);
    chk({tag, " pc_stall"},    {15'd0, bus.pc_stall},    {15'd0, t.pcs});
    chk({tag, " ifde_stall"},  {15'd0, bus.ifde_stall},  {15'd0, t.ifs});
    chk({tag, " ifde_flush"},  {15'd0, bus.ifde_flush},  {15'd0, t.fl});
    chk({tag, " deex_bubble"}, {15'd0, bus.deex_bubble}, {15'd0, t.bub});
    chk({tag, " fwd_a"},       {14'd0, bus.fwd_a},       {14'd0, t.fa});
    chk({tag, " fwd_b"},       {14'd0, bus.fwd_b},       {14'd0, t.fb});
    chk({tag, " stall_cnt"},   bus.stall_cnt,            t.cnt);
  endtask

  vec_t idle, t;

  initial begin
    idle = '0;
    //            v rs1 rs2 u1 u2 wa rw ld br bz | pcs ifs fl bub fa fb cnt
    vq.push_back('{1, 2, 0, 1, 0, 5, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0}); // lw x5
    vq.push_back('{1, 5, 1, 1, 1, 6, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 0}); // add x6,x5,x1 load-use
    vq.push_back('{1, 5, 1, 1, 1, 6, 1, 0, 0, 0,  0, 0, 0, 0, 2, 0, 1});
    vq.push_back('{1, 1, 2, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1}); // add x5
    vq.push_back('{1, 5, 5, 1, 1, 7, 1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1}); // sub x7,x5,x5
    vq.push_back('{1, 5, 0, 1, 1, 8, 1, 0, 0, 0,  0, 0, 0, 0, 2, 0, 1});
    vq.push_back('{1, 6, 5, 1, 1, 9, 1, 0, 0, 0,  0, 0, 0, 0, 0, 3, 1});
    vq.push_back('{1, 3, 0, 1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1}); // lw x0
    vq.push_back('{1, 0, 0, 1, 1,10, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1}); // reads x0
    vq.push_back('{1,10, 0, 1, 0,11, 1, 0, 1, 0,  0, 0, 1, 1, 1, 0, 1}); // branch
    vq.push_back('{1,10, 0, 1, 0,11, 1, 0, 0, 0,  0, 0, 1, 1, 2, 0, 1}); // FLUSH
    vq.push_back('{0,10, 0, 1, 0,11, 1, 0, 0, 0,  0, 0, 0, 0, 3, 0, 1}); // no valid
    vq.push_back('{1, 0, 0, 1, 0,12, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1}); // lw x12
    vq.push_back('{1,12, 0, 1, 0,13, 1, 0, 1, 0,  0, 0, 1, 1, 0, 0, 1}); // branch beats lu
    vq.push_back('{1,12, 0, 1, 0,13, 1, 0, 0, 0,  0, 0, 1, 1, 2, 0, 1});
    vq.push_back('{1,12, 0, 1, 0,14, 1, 0, 1, 1,  1, 1, 0, 0, 3, 0, 1}); // busy + branch
    vq.push_back('{1,12, 0, 1, 0,14, 1, 0, 1, 1,  1, 1, 0, 0, 3, 0, 2});
    vq.push_back('{1,12, 0, 1, 0,14, 1, 0, 1, 1,  1, 1, 0, 0, 3, 0, 3});
    vq.push_back('{1,12, 0, 1, 0,14, 1, 0, 1, 0,  0, 0, 1, 1, 3, 0, 4}); // busy falls
    vq.push_back('{1,12, 0, 1, 0,14, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 4});
    vq.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4});
    vq.push_back('{1, 0, 0, 0, 0,16, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 4}); // lw x16
    vq.push_back('{1,16, 0, 1, 0,17, 1, 0, 0, 1,  1, 1, 0, 0, 0, 0, 4}); // freeze over lu
    vq.push_back('{1,16, 0, 1, 0,17, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 5});
    vq.push_back('{1,16, 0, 1, 0,17, 1, 0, 0, 0,  0, 0, 0, 0, 2, 0, 6});

    // Reset state with hostile inputs present
    t = idle;
    t.busy = 1'b1; t.br = 1'b1; t.v = 1'b1; t.u1 = 1'b1; t.rs1 = 5'd3;
    drive(t);
    #12;
    chk_all("reset", idle);

    @(negedge clk);
    drive(idle);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i]);
    end

    // Reset asserted in FLUSH aborts it; slots are emptied.
    @(negedge clk);
    t = idle;
    t.v = 1'b1; t.u1 = 1'b1; t.rs1 = 5'd17; t.wa = 5'd18; t.rw = 1'b1; t.br = 1'b1;
    drive(t);
    @(negedge clk);
    t.br = 1'b0;
    drive(t);
    #1;
    chk("flush_before_reset", {15'd0, bus.ifde_flush}, 16'd1);
    chk("fwd_before_reset", {14'd0, bus.fwd_a}, 16'd2);
    reset = 1'b1;
    t.busy = 1'b1;
    drive(t);
    #1;
    chk_all("reset_mid_flush", idle);
    @(negedge clk);
    reset = 1'b0;
    t.busy = 1'b0;
    drive(t);
    #1;
    chk_all("after_reset", idle);

    // Saturation of the stall counter under sustained freeze.
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    t = idle;
    t.busy = 1'b1;
    drive(t);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("cnt_fffe", bus.stall_cnt, 16'hFFFE);
    @(negedge clk);
    chk("cnt_ffff", bus.stall_cnt, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("cnt_sat", bus.stall_cnt, 16'hFFFF);
    chk("freeze_pc_stall", {15'd0, bus.pc_stall}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
